// File: rtl/z80_trace_pkg.sv
// z80_trace_pkg: shared access kinds, tracer states and the trace record layout.
package z80_trace_pkg;
    typedef enum logic [2:0] {
        K_OPFETCH = 3'd0,
        K_MEMRD   = 3'd1,
        K_MEMWR   = 3'd2,
        K_IORD    = 3'd3,
        K_IOWR    = 3'd4,
        K_INTACK  = 3'd5
    } trace_kind_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } trace_state_e;

    // Record body below the timestamp; the full entry is {ts, body}.
    typedef struct packed {
        trace_kind_e kind;
        logic [15:0] addr;
        logic [7:0]  data;
    } trace_body_t;

    localparam int BODY_W = $bits(trace_body_t);
endpackage

// File: rtl/z80_bus_tracer_if.sv
// z80_bus_tracer_if: snooped tv80 bus, capture controls and trace readout port.
interface z80_bus_tracer_if #(
    parameter int DEPTH  = 64,
    parameter int TS_W   = 16,
    parameter int POST_W = 12
);
    import z80_trace_pkg::*;
    localparam int REC_W = TS_W + BODY_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              cen, m1_n, mreq_n, iorq_n, rd_n, wr_n;
    logic [15:0]       A, trig_addr;
    logic [7:0]        dout, di;
    logic              arm, stop, wrap_mode, trig_en;
    logic [POST_W-1:0] post_count;
    logic [5:0]        kind_mask;
    logic              rec_valid, rec_ready, overflow, triggered;
    logic [REC_W-1:0]  rec_data;
    logic [CNT_W-1:0]  count;
    logic [1:0]        state;

    modport master (
        output cen, m1_n, mreq_n, iorq_n, rd_n, wr_n, A, dout, di,
        output arm, stop, wrap_mode, trig_en, trig_addr, post_count, kind_mask, rec_ready,
        input  rec_valid, rec_data, count, overflow, state, triggered
    );
    modport slave (
        input  cen, m1_n, mreq_n, iorq_n, rd_n, wr_n, A, dout, di,
        input  arm, stop, wrap_mode, trig_en, trig_addr, post_count, kind_mask, rec_ready,
        output rec_valid, rec_data, count, overflow, state, triggered
    );
endinterface

// File: rtl/trace_fifo.sv
// trace_fifo: circular trace buffer with optional overwrite-oldest on full.
module trace_fifo #(
    parameter int DEPTH = 64,
    parameter int REC_W = 43
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_clr,
    input  logic                     i_push,
    input  logic                     i_wrap,
    input  logic                     i_pop,
    input  logic [REC_W-1:0]         i_wdata,
    output logic [REC_W-1:0]         o_rdata,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [REC_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr, r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop, w_wr, w_ovw;

    assign o_valid = r_count != '0;
    assign o_full  = r_count == CNT_W'(DEPTH);
    assign o_count = r_count;
    assign o_rdata = o_valid ? r_mem[r_rptr] : '0;
    assign w_pop   = i_pop & o_valid;
    assign w_wr    = i_push & (~o_full | w_pop | i_wrap);
    // Overwrite: write lands on the oldest slot, so the head moves with it.
    assign w_ovw   = w_wr & o_full & ~w_pop;

    always_ff @(posedge clk)
        if (w_wr & ~i_clr) r_mem[r_wptr] <= i_wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_pop | w_ovw) r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CNT_W'(w_wr & ~w_ovw) - CNT_W'(w_pop);
        end
    end
endmodule

// File: rtl/z80_bus_tracer.sv
// z80_bus_tracer: snoops the tv80 bus and records completed accesses into a trace FIFO.
module z80_bus_tracer
    import z80_trace_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int TS_W   = 16,
    parameter int POST_W = 12
) (
    input logic              clk,
    input logic              reset_n,
    z80_bus_tracer_if.slave  bus
);
    localparam int REC_W = TS_W + BODY_W;

    logic [TS_W-1:0]   r_ts;
    logic              r_prev_act, r_ovf, r_trig;
    trace_body_t       r_shadow;
    trace_state_e      r_state, w_next;
    logic [POST_W-1:0] r_post, w_post_nxt;
    trace_kind_e       w_kind;
    logic [7:0]        w_data;
    logic              w_active, w_evt, w_hit, w_fire, w_push, w_pop, w_full;
    logic              w_drop, w_stored, w_post_done, w_clr;

    assign w_active = (~bus.rd_n | ~bus.wr_n) & (~bus.mreq_n | ~bus.iorq_n);

    always_comb begin
        w_kind = (~bus.m1_n & ~bus.iorq_n) ? K_INTACK :
                 ~bus.iorq_n ? (~bus.wr_n ? K_IOWR : K_IORD) :
                 ~bus.wr_n ? K_MEMWR : ~bus.m1_n ? K_OPFETCH : K_MEMRD;
        w_data = (~bus.wr_n & (w_kind != K_INTACK)) ? bus.dout : bus.di;
    end

    // An access completes on the first sampled cycle after its strobes drop.
    assign w_evt       = bus.cen & ~w_active & r_prev_act;
    assign w_hit       = (r_shadow.kind == K_OPFETCH) & (r_shadow.addr == bus.trig_addr);
    assign w_fire      = w_evt & ~bus.stop & (r_state == ARMED) & w_hit;
    assign w_push      = w_evt & ~bus.stop & bus.kind_mask[r_shadow.kind] &
                         ((r_state == CAPTURE) | ((r_state == ARMED) & w_hit));
    assign w_pop       = bus.rec_valid & bus.rec_ready;
    assign w_drop      = w_push & w_full & ~w_pop & ~bus.wrap_mode;
    assign w_stored    = w_push & ~w_drop;
    assign w_post_nxt  = r_post + 1'b1;
    assign w_post_done = w_stored & (bus.post_count != '0) & (w_post_nxt == bus.post_count);
    assign w_clr       = bus.arm & ~bus.stop & ((r_state == IDLE) | (r_state == DONE));

    always_comb begin
        w_next = bus.stop ? DONE :
                 w_clr ? (bus.trig_en ? ARMED : CAPTURE) :
                 (w_drop | w_post_done) ? DONE :
                 w_fire ? CAPTURE : r_state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ts       <= '0;
            r_prev_act <= 1'b0;
            r_shadow   <= '0;
            r_state    <= IDLE;
            r_post     <= '0;
            r_ovf      <= 1'b0;
            r_trig     <= 1'b0;
        end else begin
            r_ts    <= r_ts + 1'b1;
            r_state <= w_next;
            if (bus.cen) begin
                r_prev_act <= w_active;
                if (w_active) r_shadow <= '{kind: w_kind, addr: bus.A, data: w_data};
            end
            if (w_clr) begin
                r_post <= '0;
                r_ovf  <= 1'b0;
                r_trig <= 1'b0;
            end else begin
                if (w_stored) r_post <= w_post_nxt;
                if (w_push & w_full & ~w_pop) r_ovf <= 1'b1;
                if (w_fire) r_trig <= 1'b1;
            end
        end
    end

    trace_fifo #(.DEPTH(DEPTH), .REC_W(REC_W)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_clr),
        .i_push  (w_push),
        .i_wrap  (bus.wrap_mode),
        .i_pop   (bus.rec_ready),
        .i_wdata ({r_ts, r_shadow}),
        .o_rdata (bus.rec_data),
        .o_valid (bus.rec_valid),
        .o_count (bus.count),
        .o_full  (w_full)
    );

    assign bus.overflow  = r_ovf;
    assign bus.state     = r_state;
    assign bus.triggered = r_trig;
endmodule

// File: tb/tb_z80_bus_tracer.sv
// tb_z80_bus_tracer: directed-random bench for z80_bus_tracer against a queue-based trace model.
module tb_z80_bus_tracer;
    import z80_trace_pkg::*;
    localparam int DEPTH = 4, TS_W = 16, POST_W = 12;
    localparam int REC_W = TS_W + BODY_W;

    logic clk = 1'b0, reset_n = 1'b0;
    always #5 clk = ~clk;

    z80_bus_tracer_if #(.DEPTH(DEPTH), .TS_W(TS_W), .POST_W(POST_W)) bus ();
    z80_bus_tracer #(.DEPTH(DEPTH), .TS_W(TS_W), .POST_W(POST_W)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    // Cycles since reset release: the value the free-running timestamp should hold.
    logic [15:0] cyc;
    always @(posedge clk or negedge reset_n) cyc <= !reset_n ? 16'd0 : cyc + 16'd1;

    logic [REC_W-1:0] q[$];
    int m_st = 0, m_post = 0, n_pass = 0, n_tot = 0;
    bit m_ovf = 0, m_trig = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic void model_arm();
        if (m_st == 0 || m_st == 3) begin
            q.delete();
            m_ovf = 0; m_trig = 0; m_post = 0;
            m_st = bus.trig_en ? 1 : 2;
        end
    endfunction

    function automatic void model_event(input int k, input logic [15:0] a, input logic [7:0] d,
                                        input logic [15:0] ts);
        if (m_st == 1 && k == 0 && a == bus.trig_addr) begin
            m_trig = 1;
            m_st = 2;
        end
        if (m_st != 2 || !bus.kind_mask[k]) return;
        if (q.size() == DEPTH) begin
            m_ovf = 1;
            if (!bus.wrap_mode) begin
                m_st = 3;
                return;
            end
            void'(q.pop_front());
        end
        q.push_back({ts, 3'(k), a, d});
        m_post++;
        if (bus.post_count != 0 && m_post == int'(bus.post_count)) m_st = 3;
    endfunction

    task automatic idle_bus();
        {bus.m1_n, bus.mreq_n, bus.iorq_n, bus.rd_n, bus.wr_n} = '1;
        bus.A = 16'($urandom);
    endtask

    task automatic set_strobes(input int k);
        bus.m1_n   = !(k == 0 || k == 5);
        bus.mreq_n = !(k <= 2);
        bus.iorq_n = !(k >= 3);
        bus.rd_n   = (k == 2 || k == 4);
        bus.wr_n   = !(k == 2 || k == 4);
    endtask

    // mode 0: plain access; 1: pop head on the event cycle; 2: stop on the event cycle
    task automatic access(input int k, input logic [15:0] a, input logic [7:0] d, input int mode = 0);
        @(negedge clk);
        set_strobes(k);
        bus.A    = a;
        bus.dout = (k == 2 || k == 4) ? d : 8'($urandom);
        bus.di   = (k == 2 || k == 4) ? 8'($urandom) : d;
        repeat (2) @(negedge clk);
        idle_bus();
        if (mode == 1) begin
            chk("pop_on_event_data", bus.rec_data, q[0]);
            void'(q.pop_front());
            bus.rec_ready = 1'b1;
        end
        if (mode == 2) begin
            bus.stop = 1'b1;
            m_st = 3;
        end else model_event(k, a, d, cyc);
        @(negedge clk);
        bus.rec_ready = 1'b0;
        bus.stop = 1'b0;
    endtask

    task automatic do_arm();
        @(negedge clk);
        bus.arm = 1'b1;
        model_arm();
        @(negedge clk);
        bus.arm = 1'b0;
    endtask

    task automatic do_stop();
        @(negedge clk);
        bus.stop = 1'b1;
        m_st = 3;
        @(negedge clk);
        bus.stop = 1'b0;
    endtask

    task automatic drain(input int n, input string tag);
        repeat (n) begin
            @(negedge clk);
            chk({tag, "_valid"}, bus.rec_valid, 1);
            chk({tag, "_data"}, bus.rec_data, q[0]);
            bus.rec_ready = 1'b1;
            void'(q.pop_front());
            @(posedge clk);
            #1 bus.rec_ready = 1'b0;
        end
        @(negedge clk);
        chk({tag, "_empty"}, bus.rec_valid, 0);
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_state"}, bus.state, m_st);
        chk({tag, "_count"}, bus.count, q.size());
        chk({tag, "_overflow"}, bus.overflow, m_ovf);
        chk({tag, "_triggered"}, bus.triggered, m_trig);
    endtask

    initial begin
        int kinds[7] = '{0, 2, 1, 3, 2, 4, 5};
        bus.cen = 1'b1;
        idle_bus();
        bus.dout = '0; bus.di = '0;
        bus.arm = 1'b0; bus.stop = 1'b0; bus.wrap_mode = 1'b0; bus.trig_en = 1'b0;
        bus.trig_addr = '0; bus.post_count = '0; bus.kind_mask = 6'h3F; bus.rec_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_status("reset");
        chk("reset_valid", bus.rec_valid, 0);
        chk("reset_data", bus.rec_data, 0);
        reset_n = 1'b1;

        // Free-running capture of an opcode fetch and a memory write
        do_arm();
        access(0, 16'h0000, 8'h3E);
        access(2, 16'h4000, 8'h55);
        check_status("basic");
        chk("basic_kind0", bus.rec_data[26:24], 0);
        chk("basic_data0", bus.rec_data[7:0], 8'h3E);
        chk("basic_ts_order", q[1][42:27] > q[0][42:27], 1);
        drain(2, "basic");
        do_stop();
        check_status("basic_stop");

        // Trigger on fetch at 0038, three entries post-trigger
        bus.trig_en = 1'b1; bus.trig_addr = 16'h0038; bus.post_count = 12'd3;
        do_arm();
        access(0, 16'h0000, 8'($urandom));
        access(0, 16'h0001, 8'($urandom));
        check_status("pretrig");
        access(0, 16'h0038, 8'($urandom));
        check_status("trig");
        access(1, 16'($urandom), 8'($urandom));
        access(4, 16'($urandom), 8'($urandom));
        check_status("post_done");
        drain(3, "post");

        // Full in stop mode, then full in wrap mode
        bus.trig_en = 1'b0; bus.post_count = '0;
        for (int m = 0; m < 2; m++) begin
            bus.wrap_mode = m[0];
            do_arm();
            for (int i = 0; i < 6; i++) access(int'($urandom_range(0, 4)), 16'($urandom), 8'($urandom));
            check_status(m ? "wrap_full" : "stop_full");
            drain(4, m ? "wrap" : "stopfull");
            if (m == 1) do_stop();
        end

        // Kind filter, readout hold, push+pop while full
        bus.wrap_mode = 1'b0; bus.kind_mask = 6'b000100;
        do_arm();
        foreach (kinds[i]) access(kinds[i], 16'($urandom), 8'($urandom));
        check_status("filter");
        repeat (5) begin
            @(negedge clk);
            chk("hold_data", bus.rec_data, q[0]);
        end
        access(2, 16'($urandom), 8'($urandom));
        access(2, 16'($urandom), 8'($urandom));
        check_status("filter_full");
        access(2, 16'($urandom), 8'($urandom), 1);
        check_status("pushpop_full");
        drain(4, "filter");

        // Asynchronous reset mid-capture
        do_stop();
        bus.kind_mask = 6'h3F;
        do_arm();
        access(1, 16'($urandom), 8'($urandom));
        check_status("pre_reset");
        @(negedge clk);
        set_strobes(1);
        #2 reset_n = 1'b0;
        #1;
        q.delete();
        m_st = 0; m_ovf = 0; m_trig = 0; m_post = 0;
        check_status("async_reset");
        chk("async_reset_valid", bus.rec_valid, 0);
        @(negedge clk);
        idle_bus();
        reset_n = 1'b1;

        // Stop coinciding with an event wins
        do_arm();
        access(2, 16'($urandom), 8'($urandom), 2);
        check_status("stop_event");
        chk("stop_event_valid", bus.rec_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
